// File: rtl/output_queue_scheduler.sv
// output_queue_scheduler
//   Per-(port, class) circular address FIFOs for the shared cell buffer, plus
//   a dequeue scheduler that issues at most one registered read grant per cycle.
//   Ports are served round-robin. Within the granted port the highest non-empty
//   class wins.
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   enqValid/Address/Port/Class  enqueue request for a written cell
//   enqReject                 comb: enqValid while the target queue is full
//   portEnable, psFull        per-port pause and downstream backpressure
//   deqValid/Address/Port/Class  registered read grant
//   queueEmpty                bit p*nbrOfClasses+c, decoded from the count registers
//   dropCount                 rejected enqueues, saturating at 16'hFFFF
module output_queue_scheduler #(
    parameter int nbrOfPorts   = 4,
    parameter int nbrOfClasses = 2,
    parameter int addresses    = 64,
    parameter int queueDepth   = 16,
    localparam int addressWidth    = $clog2(addresses),
    localparam int nbrOfPortsWidth = $clog2(nbrOfPorts),
    localparam int classWidth      = (nbrOfClasses > 1) ? $clog2(nbrOfClasses) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enqValid,
    input  logic [addressWidth-1:0]              enqAddress,
    input  logic [nbrOfPortsWidth-1:0]           enqPort,
    input  logic [classWidth-1:0]                enqClass,
    output logic                                 enqReject,
    input  logic [nbrOfPorts-1:0]                portEnable,
    input  logic [nbrOfPorts-1:0]                psFull,
    output logic                                 deqValid,
    output logic [addressWidth-1:0]              deqAddress,
    output logic [nbrOfPortsWidth-1:0]           deqPort,
    output logic [classWidth-1:0]                deqClass,
    output logic [nbrOfPorts*nbrOfClasses-1:0]   queueEmpty,
    output logic [15:0]                          dropCount
);
    localparam int NQ   = nbrOfPorts * nbrOfClasses;
    localparam int QIW  = $clog2(NQ);
    localparam int PTRW = $clog2(queueDepth);
    localparam int CNTW = PTRW + 1;

    logic [addressWidth-1:0]       mem_q [NQ][queueDepth];
    logic [NQ-1:0][PTRW-1:0]       wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [NQ-1:0][CNTW-1:0]       count_q, count_d;
    logic [NQ-1:0]                 notEmpty, push, pop;

    logic                          deqValid_q;
    logic [addressWidth-1:0]       deqAddress_q, deqAddress_d;
    logic [nbrOfPortsWidth-1:0]    deqPort_q, lastGranted_q;
    logic [classWidth-1:0]         deqClass_q;
    logic [15:0]                   dropCount_q;

    logic                          enqInRange, enqFull, enqAccept;
    logic [QIW-1:0]                enqIdx, gntIdx;
    logic [nbrOfPorts-1:0]         portElig;
    logic                          gntValid;
    logic [nbrOfPortsWidth-1:0]    gntPort;
    logic [classWidth-1:0]         gntClass;

    always_comb begin
        for (int q = 0; q < NQ; q++) notEmpty[q] = (count_q[q] != '0);
    end

    // Enqueue decision uses the pre-edge count only: a full queue rejects even
    // when it is being popped in the same cycle.
    always_comb begin
        enqInRange = (int'(enqPort) < nbrOfPorts) && (int'(enqClass) < nbrOfClasses);
        enqIdx     = QIW'(int'(enqPort) * nbrOfClasses + int'(enqClass));
        enqFull    = enqInRange && (count_q[enqIdx] == CNTW'(queueDepth));
        enqReject  = enqValid && enqFull;
        enqAccept  = enqValid && enqInRange && !enqFull;
    end

    // Scheduler: everything here is pre-edge state or inputs, and the result
    // only lands in registers, so deq* never sees a combinational input path.
    always_comb begin
        int p;
        p        = 0;
        gntValid = 1'b0;
        gntPort  = '0;
        gntClass = '0;
        for (int i = 0; i < nbrOfPorts; i++) begin
            portElig[i] = portEnable[i] && !psFull[i] && (|notEmpty[i*nbrOfClasses +: nbrOfClasses]);
        end
        // Search starts one past the last granted port, wrapping.
        for (int i = 1; i <= nbrOfPorts; i++) begin
            p = (int'(lastGranted_q) + i) % nbrOfPorts;
            if (!gntValid && portElig[p]) begin
                gntValid = 1'b1;
                gntPort  = nbrOfPortsWidth'(p);
            end
        end
        // Ascending scan so the highest non-empty class is the one left standing.
        for (int c = 0; c < nbrOfClasses; c++) begin
            if (notEmpty[int'(gntPort) * nbrOfClasses + c]) gntClass = classWidth'(c);
        end
        gntIdx       = QIW'(int'(gntPort) * nbrOfClasses + int'(gntClass));
        deqAddress_d = gntValid ? mem_q[gntIdx][rdPtr_q[gntIdx]] : deqAddress_q;
    end

    always_comb begin
        for (int q = 0; q < NQ; q++) begin
            push[q]    = enqAccept && (enqIdx == QIW'(q));
            pop[q]     = gntValid && (gntIdx == QIW'(q));
            wrPtr_d[q] = push[q] ? wrPtr_q[q] + 1'b1 : wrPtr_q[q];
            rdPtr_d[q] = pop[q]  ? rdPtr_q[q] + 1'b1 : rdPtr_q[q];
            case ({push[q], pop[q]})
                2'b10:   count_d[q] = count_q[q] + 1'b1;
                2'b01:   count_d[q] = count_q[q] - 1'b1;
                default: count_d[q] = count_q[q];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            deqValid_q    <= 1'b0;
            deqAddress_q  <= '0;
            deqPort_q     <= '0;
            deqClass_q    <= '0;
            dropCount_q   <= '0;
            lastGranted_q <= nbrOfPortsWidth'(nbrOfPorts - 1);
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            deqValid_q   <= gntValid;
            deqAddress_q <= deqAddress_d;
            if (gntValid) begin
                deqPort_q     <= gntPort;
                deqClass_q    <= gntClass;
                lastGranted_q <= gntPort;
            end
            if (enqReject && (dropCount_q != 16'hFFFF)) dropCount_q <= dropCount_q + 16'd1;
        end
    end

    // Storage is not reset; counts gate every read of it.
    always_ff @(posedge clk) begin
        if (enqAccept) mem_q[enqIdx][wrPtr_q[enqIdx]] <= enqAddress;
    end

    assign deqValid   = deqValid_q;
    assign deqAddress = deqAddress_q;
    assign deqPort    = deqPort_q;
    assign deqClass   = deqClass_q;
    assign queueEmpty = ~notEmpty;
    assign dropCount  = dropCount_q;
endmodule

// File: tb/tb_output_queue_scheduler.sv
// tb_output_queue_scheduler
//   Directed bench for output_queue_scheduler (4 ports, 2 classes, depth 16).
//   Table of per-cycle vectors plus hand-written sequences for queue-full,
//   no-bypass and mid-operation reset.
module tb_output_queue_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enqValid = 1'b0;
    logic [5:0] enqAddress = '0;
    logic [1:0] enqPort = '0;
    logic       enqClass = 1'b0;
    logic       enqReject;
    logic [3:0] portEnable = '0;
    logic [3:0] psFull = '0;
    logic       deqValid;
    logic [5:0] deqAddress;
    logic [1:0] deqPort;
    logic       deqClass;
    logic [7:0] queueEmpty;
    logic [15:0] dropCount;

    int checks = 0;
    int failures = 0;

    output_queue_scheduler dut (
        .clk(clk), .rst(rst),
        .enqValid(enqValid), .enqAddress(enqAddress), .enqPort(enqPort), .enqClass(enqClass),
        .enqReject(enqReject), .portEnable(portEnable), .psFull(psFull),
        .deqValid(deqValid), .deqAddress(deqAddress), .deqPort(deqPort), .deqClass(deqClass),
        .queueEmpty(queueEmpty), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        doRst;
        bit        ev;
        int        a, p, c, pe, ps;
        bit        rej, v;
        int        ea, ep, ec, qe, drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit doRst, bit ev, int a, int p, int c, int pe, int ps,
                                bit v, int ea, int ep, int ec, int qe);
        vec_t r;
        r.doRst = doRst; r.ev = ev; r.a = a; r.p = p; r.c = c; r.pe = pe; r.ps = ps;
        r.rej = 1'b0; r.v = v; r.ea = ea; r.ep = ep; r.ec = ec; r.qe = qe; r.drop = 0;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Called at a negedge; returns at a negedge with idle inputs and reset released.
    task automatic do_reset();
        enqValid = 1'b0; portEnable = '0; psFull = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Apply inputs at a negedge, check the comb reject, clock once, return at negedge.
    task automatic cycle(bit ev, int a, int p, int c, int pe, int ps, bit expRej);
        enqValid = ev; enqAddress = 6'(a); enqPort = 2'(p); enqClass = c[0];
        portEnable = 4'(pe); psFull = 4'(ps);
        #1 check("enqReject", int'(enqReject), int'(expRej));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_deq(string tag, bit v, int ea, int ep, int ec);
        check({tag, ".deqValid"}, int'(deqValid), int'(v));
        check({tag, ".deqAddress"}, int'(deqAddress), ea);
        check({tag, ".deqPort"}, int'(deqPort), ep);
        check({tag, ".deqClass"}, int'(deqClass), ec);
    endtask

    initial begin
        // Group A: single cell, two-cycle latency, data hold when idle.
        vecs.push_back(mk(1, 1,  5, 2, 0, 'hF, 0,  0,  0, 0, 0, 'hEF));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 0,  1,  5, 2, 0, 'hFF));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 0,  0,  5, 2, 0, 'hFF));
        // Group B: one cell on each port while paused, then round-robin 0..3.
        vecs.push_back(mk(1, 1, 20, 0, 0, 0, 0,    0,  0, 0, 0, 'hFE));
        vecs.push_back(mk(0, 1, 21, 1, 0, 0, 0,    0,  0, 0, 0, 'hFA));
        vecs.push_back(mk(0, 1, 22, 2, 0, 0, 0,    0,  0, 0, 0, 'hEA));
        vecs.push_back(mk(0, 1, 23, 3, 0, 0, 0,    0,  0, 0, 0, 'hAA));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 0,  1, 20, 0, 0, 'hAB));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 0,  1, 21, 1, 0, 'hAF));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 0,  1, 22, 2, 0, 'hBF));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 0,  1, 23, 3, 0, 'hFF));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 0,  0, 23, 3, 0, 'hFF));
        // Group C: strict priority, class 1 ahead of an older class-0 cell.
        vecs.push_back(mk(1, 1, 10, 1, 0, 0, 0,    0,  0, 0, 0, 'hFB));
        vecs.push_back(mk(0, 1, 11, 1, 1, 0, 0,    0,  0, 0, 0, 'hF3));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 0,  1, 11, 1, 1, 'hFB));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 0,  1, 10, 1, 0, 'hFF));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 0,  0, 10, 1, 0, 'hFF));
        // Group E: psFull[1] skips port 1, release serves it next.
        vecs.push_back(mk(1, 1, 30, 0, 0, 0, 0,    0,  0, 0, 0, 'hFE));
        vecs.push_back(mk(0, 1, 31, 1, 0, 0, 0,    0,  0, 0, 0, 'hFA));
        vecs.push_back(mk(0, 1, 32, 2, 0, 0, 0,    0,  0, 0, 0, 'hEA));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 2,  1, 30, 0, 0, 'hEB));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 2,  1, 32, 2, 0, 'hFB));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 2,  0, 32, 2, 0, 'hFB));
        vecs.push_back(mk(0, 0,  0, 0, 0, 'hF, 0,  1, 31, 1, 0, 'hFF));

        @(negedge clk);
        rst = 1'b1;
        #1;
        check_deq("reset", 0, 0, 0, 0);
        check("reset.queueEmpty", int'(queueEmpty), 'hFF);
        check("reset.dropCount", int'(dropCount), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].doRst) do_reset();
            cycle(vecs[i].ev, vecs[i].a, vecs[i].p, vecs[i].c, vecs[i].pe, vecs[i].ps, vecs[i].rej);
            check_deq($sformatf("vec%0d", i), vecs[i].v, vecs[i].ea, vecs[i].ep, vecs[i].ec);
            check($sformatf("vec%0d.queueEmpty", i), int'(queueEmpty), vecs[i].qe);
            check($sformatf("vec%0d.dropCount", i), int'(dropCount), vecs[i].drop);
        end

        // Full queue: 16 accepted, 17th rejected and lost.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1, i, 0, 0, 0, 0, 0);
        cycle(1, 63, 0, 0, 0, 0, 1);
        check("full.dropCount", int'(dropCount), 1);
        check("full.queueEmpty", int'(queueEmpty), 'hFE);
        // No bypass: still rejected on the cycle its head is granted.
        cycle(1, 62, 0, 0, 'hF, 0, 1);
        check("nobypass.dropCount", int'(dropCount), 2);
        check_deq("drain0", 1, 0, 0, 0);
        for (int i = 1; i < 16; i++) begin
            cycle(0, 0, 0, 0, 'hF, 0, 0);
            check_deq($sformatf("drain%0d", i), 1, i, 0, 0);
        end
        cycle(0, 0, 0, 0, 'hF, 0, 0);
        check("drained.deqValid", int'(deqValid), 0);
        check("drained.queueEmpty", int'(queueEmpty), 'hFF);

        // Reset with cells queued and a grant on the outputs.
        do_reset();
        cycle(1, 40, 0, 0, 0, 0, 0);
        cycle(1, 41, 1, 0, 0, 0, 0);
        cycle(1, 42, 2, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 'hF, 0, 0);
        check_deq("prerst", 1, 40, 0, 0);
        rst = 1'b1;
        #1;
        check_deq("midrst", 0, 0, 0, 0);
        check("midrst.queueEmpty", int'(queueEmpty), 'hFF);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 'hF, 0, 0);
            check($sformatf("postrst%0d.deqValid", i), int'(deqValid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
